// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and compare helper for the multi-channel PWM/window block
// Contents: pwm_mode_t (edge/center counting), pwm_dir_t (count direction),
//           pwm_cmp_lt (unsigned less-than on operands widened to PWM_CMP_W bits).
package pwm_pkg;

  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} pwm_dir_t;

  // Wide enough that count + PADDING can never wrap for any legal DATA_WIDTH.
  localparam int unsigned PWM_CMP_W = 33;

  function automatic logic pwm_cmp_lt(input logic [PWM_CMP_W-1:0] a,
                                      input logic [PWM_CMP_W-1:0] b);
    return a < b;
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// rtl/pwm_deadtime.sv - complementary output pair with dead time for one PWM channel
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   r_d        next value of the raw channel signal
//   r_q        raw channel signal (registered)
//   out        high-side drive: r_q delayed on rise by DEADTIME clks, falls with r_q
//   out_n      low-side drive: ~r_q delayed on rise by DEADTIME clks, falls with r_q rising
// DEADTIME is expected to be >= 1.
module pwm_deadtime #(
  parameter int DEADTIME = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic r_d,
  input  logic r_q,
  output logic out,
  output logic out_n
);

  localparam int RW = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(DEADTIME);
  localparam logic [RW-1:0] RUN_ONE = RW'(1);

  // run_q = clks the raw signal has held its current level, saturating at DEADTIME.
  logic [RW-1:0] run_q, run_d;
  logic          settled;

  always_comb begin
    run_d = '0;
    if (r_d == r_q) begin
      run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RUN_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  // Both outputs are gated by the same registered level, so they cannot overlap
  // and each drops on the very edge r_q leaves its level.
  assign settled = (run_q >= RUN_MAX);
  assign out     = r_q & settled;
  assign out_n   = ~r_q & settled;

endmodule

// File: rtl/pwm_window_multi.sv
// rtl/pwm_window_multi.sv - phase-locked multi-channel PWM with safe-sample windows
// Optional feature macro: PWM_WINDOW_MULTI_DEADTIME_EN (adds DEADTIME parameter and out_n port).
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   en             synchronous run enable; low clears counters and outputs
//   prescale       clks per tick (0 behaves as 1)
//   top            terminal count
//   center_mode    0 = edge-aligned, 1 = center-aligned
//   ch_en          per-channel enable
//   compare        packed per-channel compare values, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out            PWM outputs
//   out_n          complementary outputs (deadtime build only)
//   window         safe-sample windows
//   period_start   one-clk pulse after the tick that begins a period
//   count          current counter value
module pwm_window_multi
  import pwm_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 8,
  parameter int NUM_CH         = 4,
  parameter int PADDING        = 30
`ifdef PWM_WINDOW_MULTI_DEADTIME_EN
  , parameter int DEADTIME     = 4
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [PRESCALE_WIDTH-1:0]      prescale,
  input  logic [DATA_WIDTH-1:0]          top,
  input  logic                           center_mode,
  input  logic [NUM_CH-1:0]              ch_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   compare,
  output logic [NUM_CH-1:0]              out,
`ifdef PWM_WINDOW_MULTI_DEADTIME_EN
  output logic [NUM_CH-1:0]              out_n,
`endif
  output logic [NUM_CH-1:0]              window,
  output logic                           period_start,
  output logic [DATA_WIDTH-1:0]          count
);

  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE  = PRESCALE_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]     CNT_ONE = DATA_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0]    pcnt_q, pcnt_d, p_last;
  logic [DATA_WIDTH-1:0]        count_q, count_d;
  pwm_dir_t                     dir_q, dir_d;
  logic                         running_q, running_d;
  logic [DATA_WIDTH-1:0]        top_sh_q, top_sh_d;
  pwm_mode_t                    mode_sh_q, mode_sh_d;
  logic [NUM_CH-1:0]            ch_en_sh_q, ch_en_sh_d;
  logic [NUM_CH*DATA_WIDTH-1:0] cmp_sh_q, cmp_sh_d;
  logic [NUM_CH-1:0]            out_q, out_d;
  logic [NUM_CH-1:0]            window_q, window_d;
  logic                         ps_q, ps_d;
  logic                         tick;
  logic                         boundary;
  logic [PWM_CMP_W-1:0]         cnt_w, cnt_pad_w, pad_w;

  // Prescaler: a value of 0 behaves as 1. ">=" lets a prescale reduced
  // mid-run tick at once instead of running pcnt around its full range.
  assign p_last = (prescale == '0) ? '0 : prescale - PS_ONE;
  assign tick   = en && (pcnt_q >= p_last);

  // Counter and direction. running_q is cleared by reset and by en=0, so the
  // first tick afterwards restarts the period at count 0.
  always_comb begin
    pcnt_d    = pcnt_q;
    count_d   = count_q;
    dir_d     = dir_q;
    running_d = running_q;
    boundary  = 1'b0;
    if (!en) begin
      pcnt_d    = '0;
      count_d   = '0;
      dir_d     = DIR_UP;
      running_d = 1'b0;
    end else if (tick) begin
      pcnt_d    = '0;
      running_d = 1'b1;
      if (!running_q || (top_sh_q == '0)) begin
        boundary = 1'b1;
      end else if (mode_sh_q == PWM_EDGE) begin
        if (count_q >= top_sh_q) begin
          boundary = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end else if ((dir_q == DIR_UP) && (count_q < top_sh_q)) begin
        count_d = count_q + CNT_ONE;
      end else if (count_q <= CNT_ONE) begin
        // Reaching 0 from 1 ends the period; with top=1 this happens straight
        // from the peak, so it is checked before the down-count branch.
        boundary = 1'b1;
      end else begin
        count_d = count_q - CNT_ONE;
        dir_d   = DIR_DOWN;
      end
      if (boundary) begin
        count_d = '0;
        dir_d   = DIR_UP;
      end
    end else begin
      pcnt_d = pcnt_q + PS_ONE;
    end
  end

  // Shadows follow the inputs while disabled and reload only on a period-start
  // tick, so the first count of a new period already uses the new values.
  always_comb begin
    top_sh_d   = top_sh_q;
    mode_sh_d  = mode_sh_q;
    ch_en_sh_d = ch_en_sh_q;
    cmp_sh_d   = cmp_sh_q;
    if (!en || boundary) begin
      top_sh_d   = top;
      mode_sh_d  = center_mode ? PWM_CENTER : PWM_EDGE;
      ch_en_sh_d = ch_en;
      cmp_sh_d   = compare;
    end
  end

  assign cnt_w     = PWM_CMP_W'(count_q);
  assign pad_w     = PWM_CMP_W'(PADDING);
  assign cnt_pad_w = cnt_w + pad_w;

  // Channel outputs and windows, computed from the current count and shadows.
  always_comb begin
    out_d    = '0;
    window_d = '0;
    ps_d     = boundary;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en && ch_en_sh_q[i] &&
          pwm_cmp_lt(cnt_w, PWM_CMP_W'(cmp_sh_q[i*DATA_WIDTH +: DATA_WIDTH]))) begin
        out_d[i]    = 1'b1;
        // Edge mode also keeps PADDING clear of the rising edge at count 0;
        // in center mode that edge is mirrored by the descending side.
        window_d[i] = pwm_cmp_lt(cnt_pad_w, PWM_CMP_W'(cmp_sh_q[i*DATA_WIDTH +: DATA_WIDTH])) &&
                      ((mode_sh_q == PWM_CENTER) || !pwm_cmp_lt(cnt_w, pad_w));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q     <= '0;
      count_q    <= '0;
      dir_q      <= DIR_UP;
      running_q  <= 1'b0;
      top_sh_q   <= '0;
      mode_sh_q  <= PWM_EDGE;
      ch_en_sh_q <= '0;
      cmp_sh_q   <= '0;
      out_q      <= '0;
      window_q   <= '0;
      ps_q       <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      running_q  <= running_d;
      top_sh_q   <= top_sh_d;
      mode_sh_q  <= mode_sh_d;
      ch_en_sh_q <= ch_en_sh_d;
      cmp_sh_q   <= cmp_sh_d;
      out_q      <= out_d;
      window_q   <= window_d;
      ps_q       <= ps_d;
    end
  end

  assign count        = count_q;
  assign period_start = ps_q;
  assign window       = window_q;

`ifdef PWM_WINDOW_MULTI_DEADTIME_EN
  for (genvar g = 0; g < NUM_CH; g++) begin : g_dt
    pwm_deadtime #(
      .DEADTIME (DEADTIME)
    ) u_dt (
      .clk   (clk),
      .rst   (rst),
      .r_d   (out_d[g]),
      .r_q   (out_q[g]),
      .out   (out[g]),
      .out_n (out_n[g])
    );
  end
`else
  assign out = out_q;
`endif

endmodule

// File: tb/tb_pwm_window_multi.sv
// tb/tb_pwm_window_multi.sv - self-checking bench for pwm_window_multi
`timescale 1ns/1ps
module tb_pwm_window_multi;

  localparam int DW  = 8;
  localparam int PW  = 8;
  localparam int NCH = 2;
  localparam int PAD = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [PW-1:0]     prescale;
  logic [DW-1:0]     top;
  logic              center_mode;
  logic [NCH-1:0]    ch_en;
  logic [NCH*DW-1:0] compare;
  logic [NCH-1:0]    out;
  logic [NCH-1:0]    window;
  logic              period_start;
  logic [DW-1:0]     count;
`ifdef PWM_WINDOW_MULTI_DEADTIME_EN
  logic [NCH-1:0]    out_n;
`endif

  pwm_window_multi #(
    .DATA_WIDTH     (DW),
    .PRESCALE_WIDTH (PW),
    .NUM_CH         (NCH),
    .PADDING        (PAD)
`ifdef PWM_WINDOW_MULTI_DEADTIME_EN
    , .DEADTIME     (3)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .prescale     (prescale),
    .top          (top),
    .center_mode  (center_mode),
    .ch_en        (ch_en),
    .compare      (compare),
    .out          (out),
`ifdef PWM_WINDOW_MULTI_DEADTIME_EN
    .out_n        (out_n),
`endif
    .window       (window),
    .period_start (period_start),
    .count        (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position inside the period as a phase index, mapped to
  // the count value; shadows captured at period starts.
  int m_pc, m_ph, m_run;
  int sh_top, sh_mode;
  int sh_chen [NCH];
  int sh_cmp  [NCH];
  int e_count, e_ps;
  logic [NCH-1:0] e_out, e_win;

  int n_out0, n_out1, n_win0, n_ps, n_outn0, max_run0;

  function automatic int period_len(input int t, input int m);
    if (t == 0) return 1;
    return (m != 0) ? 2 * t : t + 1;
  endfunction

  function automatic int phase_to_count(input int ph, input int t, input int m);
    if (m == 0 || ph <= t) return ph;
    return 2 * t - ph;
  endfunction

  task automatic load_shadows();
    sh_top  = int'(top);
    sh_mode = int'(center_mode);
    for (int i = 0; i < NCH; i++) begin
      sh_chen[i] = int'(ch_en[i]);
      sh_cmp[i]  = int'(compare[i*DW +: DW]);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ph = 0; m_run = 0;
    sh_top = 0; sh_mode = 0;
    for (int i = 0; i < NCH; i++) begin
      sh_chen[i] = 0;
      sh_cmp[i]  = 0;
    end
    e_count = 0; e_ps = 0; e_out = '0; e_win = '0;
  endtask

  task automatic model_edge();
    int p;
    if (!en) begin
      m_pc = 0; m_ph = 0; m_run = 0;
      e_count = 0; e_ps = 0; e_out = '0; e_win = '0;
      load_shadows();
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      e_out[i] = (sh_chen[i] != 0) && (e_count < sh_cmp[i]);
      e_win[i] = e_out[i] && (e_count + PAD < sh_cmp[i]) && (sh_mode != 0 || e_count >= PAD);
    end
    p = (prescale == '0) ? 1 : int'(prescale);
    e_ps = 0;
    if (m_pc >= p - 1) begin
      m_pc = 0;
      m_ph++;
      if (m_run == 0 || m_ph >= period_len(sh_top, sh_mode)) begin
        m_ph  = 0;
        m_run = 1;
        e_ps  = 1;
        load_shadows();
      end
      e_count = phase_to_count(m_ph, sh_top, sh_mode);
    end else begin
      m_pc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    checks++;
    assert (count === DW'(e_count)) else begin
      errors++;
      $error("FAIL count got %0d exp %0d", count, e_count);
    end
    checks++;
    assert (period_start === e_ps[0]) else begin
      errors++;
      $error("FAIL period_start got %b exp %b", period_start, e_ps[0]);
    end
    checks++;
    assert (window === e_win) else begin
      errors++;
      $error("FAIL window got %b exp %b", window, e_win);
    end
`ifdef PWM_WINDOW_MULTI_DEADTIME_EN
    checks++;
    assert ((out & ~e_out) === '0) else begin
      errors++;
      $error("FAIL out_without_raw got %b raw %b", out, e_out);
    end
    checks++;
    assert ((out & out_n) === '0) else begin
      errors++;
      $error("FAIL out_overlap out %b out_n %b", out, out_n);
    end
`else
    checks++;
    assert (out === e_out) else begin
      errors++;
      $error("FAIL out got %b exp %b", out, e_out);
    end
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic measure(input int n);
    int run;
    run = 0;
    n_out0 = 0; n_out1 = 0; n_win0 = 0; n_ps = 0; n_outn0 = 0; max_run0 = 0;
    for (int k = 0; k < n; k++) begin
      step();
      n_out0 += int'(out[0]);
      n_out1 += int'(out[1]);
      n_win0 += int'(window[0]);
      n_ps   += int'(period_start);
`ifdef PWM_WINDOW_MULTI_DEADTIME_EN
      n_outn0 += int'(out_n[0]);
`endif
      if (out[0] === 1'b1) begin
        run++;
        if (run > max_run0) max_run0 = run;
      end else begin
        run = 0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int   n;

    rst = 1'b0; en = 1'b0; prescale = 8'd1; top = 8'd9; center_mode = 1'b0;
    ch_en = 2'b11; compare = {8'd0, 8'd5};
    model_reset();
    #1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_window", 32'(window), 32'd0);
    chk("rst_period_start", 32'(period_start), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) step();

    // Edge-aligned, top=9, cmp0=5, cmp1=0.
    en = 1'b1;
    repeat (15) step();
    measure(20);
`ifndef PWM_WINDOW_MULTI_DEADTIME_EN
    chk("edge_out0_high", 32'(n_out0), 32'd10);
`endif
    chk("edge_out1_high", 32'(n_out1), 32'd0);
    chk("edge_window0_high", 32'(n_win0), 32'd2);
    chk("edge_period_starts", 32'(n_ps), 32'd2);

    // Center-aligned: 18-clk period, 9 consecutive high clks.
    en = 1'b0; center_mode = 1'b1;
    step();
    en = 1'b1;
    repeat (20) step();
    measure(36);
`ifndef PWM_WINDOW_MULTI_DEADTIME_EN
    chk("center_out0_high", 32'(n_out0), 32'd18);
    chk("center_out0_run", 32'(max_run0), 32'd9);
`endif
    chk("center_period_starts", 32'(n_ps), 32'd2);

    // Shadowed compare change mid-period, prescale 4 (period 40).
    en = 1'b0; center_mode = 1'b0; prescale = 8'd4;
    step();
    en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      step();
      if (period_start === 1'b1) found = 1'b1;
    end
    chk("shadow_sync", 32'(found), 32'd1);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      n += int'(out[0]);
      if (k == 10) compare[7:0] = 8'd8;
    end
    chk("shadow_ps_after_40", 32'(period_start), 32'd1);
`ifndef PWM_WINDOW_MULTI_DEADTIME_EN
    chk("shadow_old_cmp_high", 32'(n), 32'd20);
`endif
    measure(40);
`ifndef PWM_WINDOW_MULTI_DEADTIME_EN
    chk("shadow_new_cmp_high", 32'(n_out0), 32'd32);
`endif
    chk("shadow_ps_per_40", 32'(n_ps), 32'd1);

    // cmp above top: constant high.
    en = 1'b0; prescale = 8'd1; compare[7:0] = 8'd10;
    step();
    en = 1'b1;
    repeat (5) step();
    measure(30);
    chk("cmp_gt_top_high", 32'(n_out0), 32'd30);

    // top=0: every tick starts a period.
    en = 1'b0; top = 8'd0; compare[7:0] = 8'd5;
    step();
    en = 1'b1;
    repeat (2) step();
    measure(10);
    chk("top0_period_starts", 32'(n_ps), 32'd10);

    // prescale=0 behaves as 1.
    en = 1'b0; top = 8'd9; prescale = 8'd0;
    step();
    en = 1'b1;
    repeat (15) step();
    measure(20);
    chk("prescale0_period_starts", 32'(n_ps), 32'd2);
`ifndef PWM_WINDOW_MULTI_DEADTIME_EN
    chk("prescale0_out0_high", 32'(n_out0), 32'd10);
`endif

    // Enable dropped mid-period, then restart.
    repeat (13) step();
    en = 1'b0;
    step();
    chk("dis_out", 32'(out), 32'd0);
    chk("dis_window", 32'(window), 32'd0);
    chk("dis_period_start", 32'(period_start), 32'd0);
    chk("dis_count", 32'(count), 32'd0);
    en = 1'b1;
    step();
    chk("restart_period_start", 32'(period_start), 32'd1);
    chk("restart_count", 32'(count), 32'd0);

    // Asynchronous reset between edges while out0 is high.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (out[0] === 1'b1) found = 1'b1;
    end
    chk("arst_out0_seen_high", 32'(found), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out", 32'(out), 32'd0);
    chk("arst_window", 32'(window), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_period_start", 32'(period_start), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (25) step();

    // Randomized configurations, including mid-run changes and enable toggles.
    for (int s = 0; s < 30; s++) begin
      en          = ($urandom_range(0, 3) != 0);
      prescale    = 8'($urandom_range(0, 3));
      top         = 8'($urandom_range(0, 12));
      center_mode = 1'($urandom_range(0, 1));
      ch_en       = 2'($urandom_range(0, 3));
      compare     = {8'($urandom_range(0, 14)), 8'($urandom_range(0, 14))};
      repeat ($urandom_range(5, 60)) step();
    end

`ifdef PWM_WINDOW_MULTI_DEADTIME_EN
    // Dead time 3: 5-clk raw high/low gives 2-clk out and out_n pulses.
    en = 1'b0; prescale = 8'd1; top = 8'd9; center_mode = 1'b0;
    ch_en = 2'b11; compare = {8'd0, 8'd5};
    step();
    en = 1'b1;
    repeat (15) step();
    measure(20);
    chk("dt_out0_high", 32'(n_out0), 32'd4);
    chk("dt_out_n0_high", 32'(n_outn0), 32'd4);
    chk("dt_out0_run", 32'(max_run0), 32'd2);
    en = 1'b0; compare[7:0] = 8'd2;
    step();
    en = 1'b1;
    repeat (15) step();
    measure(20);
    chk("dt_short_pulse_out0", 32'(n_out0), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
